encoder_value_ctrl: RTL and testbench
=====================================

# encoder_value_ctrl

Consumes the debounced rotary-encoder event pulses (`Left_pulse`, `Right_pulse`, `d_pulse`) produced by the encoder front end and turns them into a bounded numeric setting for the display/control logic. Each rotation event steps the value up or down. The push button toggles fine/coarse step size. Rapid same-direction rotation is accelerated. The block sits directly downstream of the encoder decoder, in the same clock domain.

## Interface
- `WIDTH`, 8: width of `value_out`.
- `MIN_VAL`, 0: lower bound, inclusive.
- `MAX_VAL`, 99: upper bound, inclusive. Must satisfy `MIN_VAL < MAX_VAL < 2**WIDTH`.
- `INIT_VAL`, 0: value loaded at reset. Must lie in `[MIN_VAL, MAX_VAL]`.
- `WRAP`, 0: 0 = saturate at bounds; 1 = wrap to the opposite bound.
- `STEP_COARSE`, 10: base step in coarse mode. Fine step is 1.
- `ACCEL`, 4: step multiplier while in fast rotation.
- `FAST_CYCLES`, 1_200_000: same-direction window for acceleration (100 ms at 12 MHz).
---
- `clk_in` input 1: system clock (12 MHz); the block's only clock.
- `rst_in` input 1: reset, asynchronous, active-high.
- `left_pulse` input 1: one-cycle counter-clockwise event; decrements.
- `right_pulse` input 1: one-cycle clockwise event; increments.
- `d_pulse` input 1: one-cycle push-button event; toggles coarse mode.
- `value_out` output WIDTH: current setting, registered.
- `coarse_out` output 1: 1 = coarse step active, registered.
- `changed_out` output 1: one-cycle strobe when `value_out` changes.
- `limit_out` output 1: one-cycle strobe when a step was clipped or wrapped at a bound.

## Operation
- **Event definition.**
  - Each cycle with exactly one of `left_pulse`/`right_pulse` high is one rotation event.
  - Both high in the same cycle: ignored. No value change, no strobes, gap counter untouched.
- **Gap counter.**
  - Counts cycles since the last accepted rotation event and saturates at `FAST_CYCLES`.
  - Cleared to 0 on every rotation event.
  - Forced to `FAST_CYCLES` on `d_pulse`.
- **Acceleration FSM**, states `SLOW`, `FAST_UP`, `FAST_DN`.
  - Any event from `SLOW` → `FAST_UP`/`FAST_DN` according to direction.
  - Event in the same direction while gap < `FAST_CYCLES` → stay in that state, apply acceleration.
  - Opposite-direction event → the other `FAST_*` state, no acceleration.
  - Gap reaching `FAST_CYCLES`, or `d_pulse` → `SLOW`.
  - Acceleration applies only to events taken while already in the matching `FAST_*` state with gap < `FAST_CYCLES`.
- **Step.** `base = coarse ? STEP_COARSE : 1`; `step = accel ? base*ACCEL : base`. Arithmetic is unsigned in WIDTH+8 bits so that no intermediate overflows.
- **Increment.**
  - If `value + step <= MAX_VAL`: `value += step`.
  - Otherwise: new value = `MAX_VAL` (WRAP=0) or `MIN_VAL` (WRAP=1), and `limit_out` pulses.
- **Decrement.**
  - If `value >= MIN_VAL + step`: `value -= step`.
  - Otherwise: new value = `MIN_VAL` (WRAP=0) or `MAX_VAL` (WRAP=1), and `limit_out` pulses.
- `changed_out` pulses only when the new value differs from the old one. A saturating step taken at the bound gives `limit_out=1`, `changed_out=0`.
- **Push button.**
  - `d_pulse` toggles `coarse_out`.
  - If it coincides with a rotation event, that event uses the old step size; the toggle and the FSM return to `SLOW` take effect afterwards.

## Timing
- Reset values: `value_out=INIT_VAL`, `coarse_out=0`, `changed_out=0`, `limit_out=0`, FSM=`SLOW`, gap=`FAST_CYCLES`.
- Latency:
  - Rotation event in cycle N → `value_out`, `changed_out` and `limit_out` valid in cycle N+1.
  - Strobes are high for exactly one cycle.
  - `d_pulse` in cycle N → `coarse_out` toggled in cycle N+1.
- Back-to-back events on consecutive cycles are each processed; there is no dropped event and no handshake.
- Reset asserted mid-operation returns every register to its reset value immediately and asynchronously; the first event after release is treated as from `SLOW`.

## Test plan
Test plan uses defaults except `FAST_CYCLES=100`.
1. Reset, then 3 `right_pulse` spaced 200 cycles apart → `value_out` 1, 2, 3; `changed_out` pulses ×3; `limit_out` never high.
2. `d_pulse`, then 2 `right_pulse` 200 cycles apart from value 0 → `coarse_out=1`; `value_out` 10, 20.
3. Fine mode, value 0, 4 `right_pulse` 10 cycles apart → `value_out` 1, 5, 9, 13. Then a `left_pulse` 10 cycles later → 12, unaccelerated.
4. WRAP=0, value 98, 2 `right_pulse` 200 apart → 99 (`changed=1`, `limit=0`), then 99 (`changed=0`, `limit=1`). A `left_pulse` at 0 → stays 0 with `limit=1`.
5. WRAP=1, value 95, coarse mode, `right_pulse` → 0 with `limit=1`, `changed=1`. `left_pulse` at 0 → 99.
6. `left_pulse` and `right_pulse` in the same cycle → no change. `d_pulse` coincident with `right_pulse` in fine mode at value 0 → value 1 and `coarse_out=1` in the next cycle. `rst_in` pulsed mid-sequence → all outputs at reset values.

Source files
------------

// File: rtl/encoder_value_ctrl.sv
// Bounded up/down setting driven by rotary-encoder event pulses, with a
// coarse/fine step toggle and acceleration on rapid same-direction rotation.
module encoder_value_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MIN_VAL     = 0,
  parameter int unsigned MAX_VAL     = 99,
  parameter int unsigned INIT_VAL    = 0,
  parameter int unsigned WRAP        = 0,
  parameter int unsigned STEP_COARSE = 10,
  parameter int unsigned ACCEL       = 4,
  parameter int unsigned FAST_CYCLES = 1_200_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             left_pulse,
  input  logic             right_pulse,
  input  logic             d_pulse,
  output logic [WIDTH-1:0] value_out,
  output logic             coarse_out,
  output logic             changed_out,
  output logic             limit_out
);

  localparam int unsigned GW = $clog2(FAST_CYCLES + 1);
  localparam int unsigned SW = WIDTH + 8;

  typedef enum logic [1:0] {StSlow, StFastUp, StFastDn} state_t;

  state_t           r_state, w_state_nxt;
  logic [GW-1:0]    r_gap, w_gap_nxt;
  logic [WIDTH-1:0] r_value, w_value_nxt;
  logic             r_coarse, r_changed, r_limit;
  logic             w_changed_nxt, w_limit_nxt;

  logic             w_evt, w_up, w_gap_full, w_accel;
  logic [SW-1:0]    w_base, w_step, w_cur, w_sum;

  always_comb begin
    w_evt      = left_pulse ^ right_pulse;
    w_up       = right_pulse;
    w_gap_full = (r_gap == GW'(FAST_CYCLES));
    w_accel    = w_evt && !w_gap_full &&
                 ((r_state == StFastUp && w_up) || (r_state == StFastDn && !w_up));
    w_base     = r_coarse ? SW'(STEP_COARSE) : SW'(1);
    w_step     = w_accel ? (w_base * SW'(ACCEL)) : w_base;
    w_cur      = SW'(r_value);
    w_sum      = w_cur + w_step;
  end

  // Value update; an out-of-range step clips or wraps and flags the limit strobe.
  always_comb begin
    w_value_nxt = r_value;
    w_limit_nxt = 1'b0;
    if (w_evt) begin
      if (w_up) begin
        if (w_sum <= SW'(MAX_VAL)) begin
          w_value_nxt = WIDTH'(w_sum);
        end else begin
          w_value_nxt = (WRAP != 0) ? WIDTH'(MIN_VAL) : WIDTH'(MAX_VAL);
          w_limit_nxt = 1'b1;
        end
      end else begin
        if (w_cur >= SW'(MIN_VAL) + w_step) begin
          w_value_nxt = WIDTH'(w_cur - w_step);
        end else begin
          w_value_nxt = (WRAP != 0) ? WIDTH'(MAX_VAL) : WIDTH'(MIN_VAL);
          w_limit_nxt = 1'b1;
        end
      end
    end
    w_changed_nxt = (w_value_nxt != r_value);
  end

  // d_pulse wins over a coincident event so the return to slow happens afterwards.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    if (d_pulse) begin
      w_state_nxt = StSlow;
      w_gap_nxt   = GW'(FAST_CYCLES);
    end else if (w_evt) begin
      w_state_nxt = w_up ? StFastUp : StFastDn;
      w_gap_nxt   = '0;
    end else if (w_gap_full) begin
      w_state_nxt = StSlow;
    end else begin
      w_gap_nxt = r_gap + GW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= StSlow;
      r_gap     <= GW'(FAST_CYCLES);
      r_value   <= WIDTH'(INIT_VAL);
      r_coarse  <= 1'b0;
      r_changed <= 1'b0;
      r_limit   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap     <= w_gap_nxt;
      r_value   <= w_value_nxt;
      r_coarse  <= r_coarse ^ d_pulse;
      r_changed <= w_changed_nxt;
      r_limit   <= w_limit_nxt;
    end
  end

  assign value_out   = r_value;
  assign coarse_out  = r_coarse;
  assign changed_out = r_changed;
  assign limit_out   = r_limit;

endmodule

// File: tb/tb_encoder_value_ctrl.sv
// Directed bench for encoder_value_ctrl: a saturating and a wrapping instance share
// stimulus; a reference model pushes expected outputs that are popped after each edge.
module tb_encoder_value_ctrl;

  localparam int Fast = 100;

  logic       clk = 1'b0, rst = 1'b1, lp = 1'b0, rp = 1'b0, dp = 1'b0;
  logic [7:0] v0, v1;
  logic       c0, c1, ch0, ch1, l0, l1;

  always #5 clk = ~clk;

  encoder_value_ctrl #(.FAST_CYCLES(Fast), .WRAP(0)) u_sat (
    .clk_in(clk), .rst_in(rst), .left_pulse(lp), .right_pulse(rp), .d_pulse(dp),
    .value_out(v0), .coarse_out(c0), .changed_out(ch0), .limit_out(l0)
  );

  encoder_value_ctrl #(.FAST_CYCLES(Fast), .WRAP(1)) u_wrap (
    .clk_in(clk), .rst_in(rst), .left_pulse(lp), .right_pulse(rp), .d_pulse(dp),
    .value_out(v1), .coarse_out(c1), .changed_out(ch1), .limit_out(l1)
  );

  typedef struct {int val; int crs; int chg; int lim;} exp_t;
  exp_t q[$];

  int total = 0, bad = 0, cyc = 0;
  int m_val[2];
  int m_crs, last_cyc;
  bit hist, last_up;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int idx, input exp_t e);
    logic [7:0] av;
    logic       ac, ach, al;
    if (idx == 0) begin av = v0; ac = c0; ach = ch0; al = l0; end
    else          begin av = v1; ac = c1; ach = ch1; al = l1; end
    chk($sformatf("%s/d%0d/value", tag, idx),   {24'd0, av}, e.val);
    chk($sformatf("%s/d%0d/coarse", tag, idx),  {31'd0, ac}, e.crs);
    chk($sformatf("%s/d%0d/changed", tag, idx), {31'd0, ach}, e.chg);
    chk($sformatf("%s/d%0d/limit", tag, idx),   {31'd0, al}, e.lim);
  endtask

  task automatic model_reset();
    m_val[0] = 0; m_val[1] = 0; m_crs = 0; hist = 0;
  endtask

  // One stimulus cycle: model predicts, DUT outputs are checked after the edge.
  task automatic drive(input bit l, input bit r, input bit d, input string tag);
    bit   evt, acc;
    int   base, st, v, nv, lim;
    exp_t e;
    @(negedge clk);
    lp = l; rp = r; dp = d;
    evt  = l ^ r;
    acc  = evt && hist && (last_up == r) && ((cyc - last_cyc) <= Fast);
    base = (m_crs != 0) ? 10 : 1;
    st   = acc ? base * 4 : base;
    if (evt) begin hist = 1; last_up = r; last_cyc = cyc; end
    if (d) begin m_crs = m_crs ^ 1; hist = 0; end
    for (int i = 0; i < 2; i++) begin
      v = m_val[i]; nv = v; lim = 0;
      if (evt && r) begin
        if (v + st <= 99) nv = v + st;
        else begin nv = (i == 1) ? 0 : 99; lim = 1; end
      end else if (evt) begin
        if (v >= st) nv = v - st;
        else begin nv = (i == 1) ? 99 : 0; lim = 1; end
      end
      e.val = nv; e.crs = m_crs; e.chg = (nv != v) ? 1 : 0; e.lim = lim;
      m_val[i] = nv;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    lp = 0; rp = 0; dp = 0;
    for (int i = 0; i < 2; i++) check_dut(tag, i, q.pop_front());
  endtask

  // Idle cycles; the first one confirms the strobes lasted a single cycle.
  task automatic idle(input int n);
    if (n > 0) begin
      @(posedge clk);
      #1;
      chk("strobe_drop/changed0", {31'd0, ch0}, 0);
      chk("strobe_drop/limit0",   {31'd0, l0},  0);
      chk("strobe_drop/changed1", {31'd0, ch1}, 0);
      chk("strobe_drop/limit1",   {31'd0, l1},  0);
      repeat (n - 1) @(posedge clk);
    end
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e.val = 0; e.crs = 0; e.chg = 0; e.lim = 0;
    check_dut(tag, 0, e);
    check_dut(tag, 1, e);
  endtask

  // Asynchronous reset: outputs checked before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1;
    #1;
    check_reset(tag);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 0;
    idle(5);

    repeat (3) begin drive(0, 1, 0, "t1_fine_up"); idle(199); end
    repeat (3) begin drive(1, 0, 0, "t1_fine_dn"); idle(199); end

    drive(0, 0, 1, "t2_press");      idle(199);
    repeat (2) begin drive(0, 1, 0, "t2_coarse_up"); idle(199); end
    repeat (2) begin drive(1, 0, 0, "t2_coarse_dn"); idle(199); end
    drive(0, 0, 1, "t2_unpress");    idle(199);

    repeat (4) begin drive(0, 1, 0, "t3_accel_up"); idle(9); end
    drive(1, 0, 0, "t3_reverse");    idle(199);

    drive(0, 0, 1, "t4_press");      idle(199);
    repeat (8) begin drive(0, 1, 0, "t4_climb_c"); idle(199); end
    drive(0, 0, 1, "t4_unpress");    idle(199);
    repeat (6) begin drive(0, 1, 0, "t4_climb_f"); idle(199); end
    drive(0, 1, 0, "t4_to_max");     idle(199);
    drive(0, 1, 0, "t4_at_max");     idle(199);
    do_reset("t4_mid_reset");        idle(5);
    drive(1, 0, 0, "t4_dn_at_min");  idle(199);

    do_reset("t5_reset");            idle(5);
    drive(0, 0, 1, "t5_press");      idle(199);
    repeat (9) begin drive(0, 1, 0, "t5_climb_c"); idle(199); end
    drive(0, 0, 1, "t5_unpress");    idle(199);
    repeat (5) begin drive(0, 1, 0, "t5_climb_f"); idle(199); end
    drive(0, 0, 1, "t5_press2");     idle(199);
    drive(0, 1, 0, "t5_over_max");   idle(199);
    drive(1, 0, 0, "t5_dn_after");   idle(199);

    drive(1, 1, 0, "t6_both");       idle(10);
    do_reset("t6_reset");            idle(5);
    drive(0, 1, 1, "t6_press_rot");
    drive(0, 1, 0, "t6_b2b_a");
    drive(0, 1, 0, "t6_b2b_b");      idle(3);
    do_reset("t6_final_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
